// File: rtl/screen_pkg.sv
// Shared constants, register map and FSM encoding for the LED-matrix frame loader.
package screen_pkg;

  localparam int NUM_COLS   = 64;
  localparam int NUM_ROWS   = 64;
  localparam int NUM_PIXELS = NUM_COLS * NUM_ROWS;
  localparam int BIT_DEPTH  = 4;
  localparam int PIX_W      = 3 * BIT_DEPTH;

  // One extra bit so the counter can hold NUM_PIXELS itself after the final pop.
  localparam int CNT_W = $clog2(NUM_PIXELS) + 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIXELS - 1);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_FULL    = 2;
  localparam int STAT_EMPTY   = 3;
  localparam int STAT_OVF     = 4;
  localparam int STAT_CNT_LSB = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_GAP,
    ST_STREAM,
    ST_DONE
  } state_e;

  function automatic logic [31:0] pack_status(input logic busy, input logic done,
                                              input logic full, input logic empty,
                                              input logic ovf,
                                              input logic [CNT_W-1:0] cnt);
    logic [31:0] s;
    s = '0;
    s[STAT_BUSY]                 = busy;
    s[STAT_DONE]                 = done;
    s[STAT_FULL]                 = full;
    s[STAT_EMPTY]                = empty;
    s[STAT_OVF]                  = ovf;
    s[STAT_CNT_LSB +: CNT_W]     = cnt;
    return s;
  endfunction

endpackage

// File: rtl/screen_pix_fifo.sv
// Synchronous pixel FIFO; a push into a full FIFO is accepted only alongside a pop.
module screen_pix_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/screen_frame_loader.sv
// Bus-side frame uploader: buffers CPU pixels, pulses the driver's init, then
// streams exactly one frame of wr_data/mat_in writes.
module screen_frame_loader
  import screen_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int INIT_HIGH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  bus_addr,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic [31:0] mat_in,
  output logic        wr_data,
  output logic        init,
  output logic        irq
);

  localparam int ICW = (INIT_HIGH > 1) ? $clog2(INIT_HIGH) : 1;
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_HIGH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] pix_cnt_q;
  logic [ICW-1:0]   init_cnt_q;
  logic             done_q;
  logic             ovf_q;
  logic             irq_en_q;
  logic             init_q;
  logic             wr_data_q;
  logic [PIX_W-1:0] mat_q;
  logic [31:0]      rdata_q;
  logic [31:0]      rdata_d;

  logic             ctrl_wr;
  logic             data_wr;
  logic             stat_rd;
  logic             start;
  logic             abort;
  logic             pop;
  logic             busy;
  logic             ovf_set;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PIX_W-1:0] fifo_rdata;
  logic             unused_wdata;

  assign ctrl_wr = bus_wr && (bus_addr == REG_CTRL);
  assign data_wr = bus_wr && (bus_addr == REG_DATA);
  assign stat_rd = bus_rd && (bus_addr == REG_STATUS);
  assign abort   = ctrl_wr && bus_wdata[CTRL_ABORT];
  assign start   = ctrl_wr && bus_wdata[CTRL_START];
  assign pop     = (state_q == ST_STREAM) && !fifo_empty && !abort;
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign ovf_set = data_wr && fifo_full && !pop;

  assign unused_wdata = ^bus_wdata[31:PIX_W];

  screen_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (abort),
    .push_i  (data_wr),
    .pop_i   (pop),
    .wdata_i (bus_wdata[PIX_W-1:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    rdata_d = '0;
    case (bus_addr)
      REG_CTRL:   rdata_d[CTRL_IRQ_EN] = irq_en_q;
      REG_STATUS: rdata_d = pack_status(busy, done_q, fifo_full, fifo_empty,
                                        ovf_q, pix_cnt_q);
      default:    rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pix_cnt_q  <= '0;
      init_cnt_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      init_q     <= 1'b0;
      wr_data_q  <= 1'b0;
      mat_q      <= '0;
      rdata_q    <= '0;
    end else begin
      wr_data_q <= 1'b0;
      if (ctrl_wr) irq_en_q <= bus_wdata[CTRL_IRQ_EN];
      if (bus_rd)  rdata_q  <= rdata_d;

      // Later assignments win: a same-cycle set beats the read-to-clear.
      if (stat_rd) begin
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
      end
      if (ovf_set) ovf_q <= 1'b1;

      if (abort) begin
        state_q <= ST_IDLE;
        init_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (start) begin
            state_q    <= ST_INIT;
            init_q     <= 1'b1;
            init_cnt_q <= '0;
            pix_cnt_q  <= '0;
            done_q     <= 1'b0;
          end
          ST_INIT: if (init_cnt_q == INIT_LAST) begin
            state_q <= ST_GAP;
            init_q  <= 1'b0;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
          ST_GAP: state_q <= ST_STREAM;
          ST_STREAM: if (pop) begin
            mat_q     <= fifo_rdata;
            wr_data_q <= 1'b1;
            pix_cnt_q <= pix_cnt_q + 1'b1;
            if (pix_cnt_q == LAST_PIX) state_q <= ST_DONE;
          end
          ST_DONE: begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus_rdata = rdata_q;
  assign mat_in    = {{(32-PIX_W){1'b0}}, mat_q};
  assign wr_data   = wr_data_q;
  assign init      = init_q;
  assign irq       = done_q && irq_en_q;

endmodule

// File: tb/tb_screen_frame_loader.sv
// Scoreboard bench for screen_frame_loader: stimulus queues expected pixels and
// read data; a negedge monitor pops and compares whenever the DUT presents them.
module tb_screen_frame_loader;
  import screen_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  bus_addr = 2'd0;
  logic        bus_wr = 1'b0;
  logic        bus_rd = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic [31:0] mat_in;
  logic        wr_data;
  logic        init;
  logic        irq;

  screen_frame_loader dut (
    .clk       (clk),
    .reset     (reset),
    .bus_addr  (bus_addr),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .mat_in    (mat_in),
    .wr_data   (wr_data),
    .init      (init),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_pix[$];
  logic [31:0] exp_rd[$];
  string       exp_rd_name[$];
  int          wr_cnt = 0;
  logic        rd_seen = 1'b0;
  int          init_run = 0;
  int          last_init_len = 0;
  int          init_falls = 0;
  int          gap_cnt = 0;
  int          last_gap = 0;
  logic        gap_armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: read data appears the cycle after bus_rd; pixels whenever wr_data is high.
  always @(posedge clk) rd_seen <= bus_rd;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got 0x%0h with nothing expected", bus_rdata);
      end else begin
        check(exp_rd_name.pop_front(), bus_rdata, exp_rd.pop_front());
      end
    end
    if (wr_data) begin
      wr_cnt++;
      if (exp_pix.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr_data: got mat_in 0x%0h with nothing expected", mat_in);
      end else begin
        check("pixel", mat_in, {20'h0, exp_pix.pop_front()});
      end
    end
    if (init) begin
      init_run++;
    end else if (init_run != 0) begin
      last_init_len = init_run;
      init_run      = 0;
      init_falls++;
      gap_cnt       = 1;
      gap_armed     = 1'b1;
    end else if (gap_armed) begin
      if (wr_data) begin
        last_gap  = gap_cnt;
        gap_armed = 1'b0;
      end else begin
        gap_cnt++;
      end
    end
  end

  task automatic nop();
    @(negedge clk);
    bus_wr = 1'b0;
    bus_rd = 1'b0;
  endtask

  task automatic ctrl_write(input logic [31:0] v);
    @(negedge clk);
    bus_addr  = REG_CTRL;
    bus_wr    = 1'b1;
    bus_rd    = 1'b0;
    bus_wdata = v;
  endtask

  task automatic push_pix(input logic [11:0] p, input logic accepted);
    @(negedge clk);
    bus_addr  = REG_DATA;
    bus_wr    = 1'b1;
    bus_rd    = 1'b0;
    bus_wdata = {20'hABCDE, p};
    if (accepted) exp_pix.push_back(p);
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    bus_addr = a;
    bus_rd   = 1'b1;
    bus_wr   = 1'b0;
    exp_rd.push_back(exp);
    exp_rd_name.push_back(name);
  endtask

  task automatic wait_wr(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (wr_cnt < target && n < budget) begin
      @(negedge clk);
      bus_wr = 1'b0;
      bus_rd = 1'b0;
      #1;
      n++;
    end
    check(name, wr_cnt, target);
  endtask

  initial begin
    int base;
    int falls0;

    // Reset state.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus_read(REG_STATUS, 32'h0000_0008, "status_after_reset");
    nop();
    #1;
    check("init_after_reset", init, 0);
    check("wr_data_after_reset", wr_data, 0);
    check("irq_after_reset", irq, 0);

    // Full frame, back-to-back pushes of 0x000..0xFFF.
    base = wr_cnt;
    ctrl_write(32'h1);
    for (int i = 0; i < NUM_PIXELS; i++) push_pix(12'(i), 1'b1);
    wait_wr(base + NUM_PIXELS, 200, "frame1_wr_count");
    check("frame1_init_len", last_init_len, 2);
    check("frame1_init_to_data", last_gap, 2);
    bus_read(REG_STATUS, 32'h0002_000A, "frame1_status_done");
    bus_read(REG_STATUS, 32'h0002_0008, "frame1_status_done_cleared");
    nop();

    // Overflow while idle: 8 fill the FIFO, the 9th is dropped.
    for (int i = 0; i < 8; i++) push_pix(12'(12'h100 + i), 1'b0);
    bus_read(REG_STATUS, 32'h0002_0004, "fifo_full_no_ovf");
    push_pix(12'h1FF, 1'b0);
    bus_read(REG_STATUS, 32'h0002_0014, "ovf_set");
    bus_read(REG_STATUS, 32'h0002_0004, "ovf_cleared_by_read");
    ctrl_write(32'h2);
    bus_read(REG_STATUS, 32'h0002_0008, "abort_flushes_fifo");
    nop();

    // Abort mid-frame after 100 pixels; a start while busy is ignored.
    base = wr_cnt;
    ctrl_write(32'h1);
    for (int i = 0; i < 50; i++) push_pix(12'(i * 37), 1'b1);
    ctrl_write(32'h1);
    for (int i = 50; i < 100; i++) push_pix(12'(i * 37), 1'b1);
    wait_wr(base + 100, 50, "abort_run_wr_count");
    ctrl_write(32'h2);
    bus_read(REG_STATUS, 32'h0000_0C88, "status_after_abort");
    repeat (10) nop();
    check("no_wr_after_abort", wr_cnt, base + 100);

    // irq-enabled frame.
    base = wr_cnt;
    ctrl_write(32'h5);
    for (int i = 0; i < NUM_PIXELS; i++) push_pix(12'(i * 5 + 3), 1'b1);
    wait_wr(base + NUM_PIXELS, 200, "frame2_wr_count");
    check("irq_low_at_last_wr", irq, 0);
    nop();
    #1;
    check("irq_high_after_last_wr", irq, 1);
    bus_read(REG_STATUS, 32'h0002_000A, "frame2_status_done");
    nop();
    #1;
    check("irq_dropped_by_status_read", irq, 0);
    bus_read(REG_CTRL, 32'h0000_0004, "ctrl_readback");
    nop();

    // Synchronous reset mid-stream around pixel 2000.
    base = wr_cnt;
    ctrl_write(32'h5);
    for (int i = 0; i < NUM_PIXELS; i++) begin
      push_pix(12'(i), 1'b1);
      #1;
      if (wr_cnt - base >= 2000) break;
    end
    @(negedge clk);
    bus_wr = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    #1;
    exp_pix.delete();
    check("rst_init", init, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_mat_in", mat_in, 0);
    check("rst_bus_rdata", bus_rdata, 0);
    check("rst_irq", irq, 0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(REG_STATUS, 32'h0000_0008, "status_after_midframe_reset");
    falls0 = init_falls;
    ctrl_write(32'h1);
    repeat (6) nop();
    #1;
    check("reinit_pulse_seen", init_falls, falls0 + 1);
    check("reinit_pulse_len", last_init_len, 2);
    ctrl_write(32'h2);
    bus_read(REG_STATUS, 32'h0000_0008, "status_after_final_abort");
    repeat (3) nop();

    check("pixels_outstanding", exp_pix.size(), 0);
    check("reads_outstanding", exp_rd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
